spi_word_receiver: RTL and testbench
====================================

// Module: spi_word_receiver
// PURPOSE
//  Parametrised SPI slave receive path, fully synchronous to the system clock.
//  - Oversamples spi_sclk/spi_mosi/spi_cs_n and assembles WORD_W-bit words in the selected SPI mode.
//  - On each complete word, emits the word with a one-cycle write_pulse and an auto-incrementing
//    address, for writing directly into on-chip RAM.
//  - Counts received bytes. Flags frames that end mid-word.
// PARAMETERS
//  WORD_W      16  bits per word; multiple of 8, range 8..32
//  ADDR_W      15  width of write address counter
//  CNT_W       16  width of byte counter
//  CPOL        0   idle level of spi_sclk
//  CPHA        0   0: sample on leading edge; 1: sample on trailing edge
//  MSB_FIRST   1   1: first bit received lands in bit WORD_W-1; 0: lands in bit 0
//  SYNC_STAGES 2   synchroniser depth on all SPI inputs, >=2
// PORTS
//  clk            in   1       system clock; must be >= 4x spi_sclk frequency
//  reset          in   1       asynchronous reset, active-high
//  clear          in   1       synchronous clear of address, byte_count, frame_error, bit counter
//  spi_sclk       in   1       SPI clock (asynchronous to clk)
//  spi_mosi       in   1       SPI data in
//  spi_cs_n       in   1       SPI chip select, active-low
//  word_out       out  WORD_W  last completed word; held until the next word completes
//  address        out  ADDR_W  RAM address of word_out; valid while write_pulse is high
//  write_pulse    out  1       high for exactly one clk cycle per completed word
//  byte_count     out  CNT_W   total bytes received since reset/clear
//  frame_active   out  1       synchronised spi_cs_n is low
//  frame_error    out  1       sticky; spi_cs_n rose with bit counter != 0
// BEHAVIOUR
//  Reset values
//  - All outputs and internal registers are 0 on reset.
//  - Synchroniser flops reset to sclk=CPOL, cs_n=1, mosi=0.
//  Input synchronisation and edge detection
//  - Each SPI input passes through SYNC_STAGES flops; sclk_s and mosi_s are the final stages.
//  - sclk_d = sclk_s delayed by one clk.
//  - Sample edge: rising (sclk_s & ~sclk_d) when CPOL==CPHA, falling otherwise.
//  - Edges are ignored while cs_s is high.
//  Per sample edge, in cycle N (registers update at the end of N)
//  - mosi_s is shifted into the shift register per MSB_FIRST.
//  - bit_cnt increments.
//  - If bit_cnt == WORD_W-1:
//    - word_out <= assembled word including the current bit;
//    - write_pulse <= 1 (high in N+1 only);
//    - address for this word = current counter; counter then increments by 1, wrapping 2^ADDR_W-1 -> 0;
//    - byte_count += WORD_W/8, wrapping modulo 2^CNT_W;
//    - bit_cnt <= 0.
//  - First word after reset/clear is written at address 0.
//  Latency
//  - Pin edge to write_pulse = SYNC_STAGES+1 clk cycles, ±1 cycle synchroniser uncertainty.
//  cs_n framing
//  - Synchronised rising edge of cs_n:
//    - bit_cnt <= 0 and the partial word is discarded;
//    - if bit_cnt != 0, frame_error <= 1.
//  - address and byte_count persist across frames; only reset or clear zeroes them.
//  Boundary conditions
//  - clear and word completion in the same cycle: clear wins; no write_pulse; counters = 0.
//  - Sample edge and cs_n rise in the same cycle: the cs_n rise wins and the edge is dropped.
//  - Reset mid-word: partial data lost; address restarts at 0.
//  - Two words completing back-to-back produce separate pulses; guaranteed by the clk >= 4x sclk rule.
// STRUCTURE
//  - Package spi_rx_pkg:
//    - function sample_rising(cpol, cpha);
//    - localparam BYTES_PER_WORD helper;
//    - typedef spi_mode_t {MODE0..MODE3}.
//  - Sub-module spi_input_sync:
//    - parametrised depth and reset value; 1-bit synchroniser;
//    - instantiated for sclk, mosi and cs_n.
//  - Edge detect, shift register, counters and framing logic live in this module.
// TESTING
//  - Mode 0, WORD_W=16, MSB_FIRST, cs_n low, send 0xA55A then 0x1234:
//    - write_pulse x2 with word_out=0xA55A @addr 0, then 0x1234 @addr 1;
//    - byte_count=4; frame_error=0.
//  - Modes 1, 2 and 3, plus MSB_FIRST=0, send 0x00F1:
//    - word_out matches the sent value in every mode;
//    - with MSB_FIRST=0 the first bit sent lands in bit 0.
//  - cs_n raised after 7 bits, then a full 0xBEEF sent:
//    - frame_error=1 and stays 1;
//    - the next word is 0xBEEF at the next address with no stale bits.
//  - ADDR_W=2, send 5 words:
//    - addresses 0,1,2,3,0;
//    - byte_count=10.
//  - clear asserted in the write_pulse cycle:
//    - no pulse; address, byte_count and frame_error read 0;
//    - next word is written at addr 0.
//  - Async reset asserted mid-word:
//    - all outputs 0 immediately;
//    - after release, a full word is received correctly at addr 0.

Source files
------------

// File: rtl/spi_rx_pkg.sv
// Shared types and helpers for the SPI word receiver.
//   spi_mode_t     : SPI mode encoding {CPOL, CPHA}
//   sample_rising  : 1 when the sampling edge of spi_sclk is a rising edge
//   bytes_per_word : number of bytes in one received word
`timescale 1ns/1ps
package spi_rx_pkg;

   typedef enum logic [1:0] {
      MODE0 = 2'b00,
      MODE1 = 2'b01,
      MODE2 = 2'b10,
      MODE3 = 2'b11
   } spi_mode_t;

   localparam int BITS_PER_BYTE = 8;

   // Leading edge is rising when CPOL=0; CPHA=1 moves sampling to the
   // trailing edge, so the sample edge is rising exactly when CPOL==CPHA.
   function automatic logic sample_rising(input logic cpol, input logic cpha);
      return (cpol == cpha);
   endfunction

   function automatic int bytes_per_word(input int word_w);
      return word_w / BITS_PER_BYTE;
   endfunction

endpackage

// File: rtl/spi_word_receiver_if.sv
// Bus bundle of the SPI word receiver.
//   slave  : receiver side (SPI pins and clear in, word/RAM-write/status out)
//   master : driver side (testbench or SoC glue)
`timescale 1ns/1ps
interface spi_word_receiver_if #(
   parameter int WORD_W = 16,
   parameter int ADDR_W = 15,
   parameter int CNT_W  = 16
);
   logic              clear;
   logic              spi_sclk;
   logic              spi_mosi;
   logic              spi_cs_n;
   logic [WORD_W-1:0] word_out;
   logic [ADDR_W-1:0] address;
   logic              write_pulse;
   logic [CNT_W-1:0]  byte_count;
   logic              frame_active;
   logic              frame_error;

   modport slave (
      input  clear, spi_sclk, spi_mosi, spi_cs_n,
      output word_out, address, write_pulse, byte_count, frame_active, frame_error
   );

   modport master (
      output clear, spi_sclk, spi_mosi, spi_cs_n,
      input  word_out, address, write_pulse, byte_count, frame_active, frame_error
   );
endinterface

// File: rtl/spi_input_sync.sv
// Single-bit multi-flop synchroniser with selectable reset value.
//   clk, reset : system clock, async active-high reset
//   i_d        : asynchronous input
//   o_q        : synchronised output (last stage)
`timescale 1ns/1ps
module spi_input_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);
   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_sync <= {STAGES{RESET_VAL}};
      else       r_sync <= {r_sync[STAGES-2:0], i_d};
   end

   assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/spi_word_receiver.sv
// SPI slave receive path, oversampled on clk. Assembles WORD_W-bit words in
// the selected SPI mode and emits each with a one-cycle write pulse and an
// auto-incrementing RAM address; counts bytes and flags truncated frames.
//   clk, reset : system clock (>= 4x sclk), async active-high reset
//   bus.slave  : clear, spi_sclk/mosi/cs_n in; word_out, address,
//                write_pulse, byte_count, frame_active, frame_error out
`timescale 1ns/1ps
module spi_word_receiver
   import spi_rx_pkg::*;
#(
   parameter int WORD_W      = 16,
   parameter int ADDR_W      = 15,
   parameter int CNT_W       = 16,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int MSB_FIRST   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   spi_word_receiver_if.slave bus
);
   localparam int        BC_W        = $clog2(WORD_W);
   localparam spi_mode_t MODE        = spi_mode_t'({1'(CPOL), 1'(CPHA)});
   localparam logic      SAMPLE_RISE = sample_rising(MODE[1], MODE[0]);

   logic w_sclk_s, w_mosi_s, w_cs_s;
   logic w_edge, w_cs_rise;
   logic [WORD_W-1:0] w_next_word;

   logic              r_sclk_d, r_cs_d;
   logic [WORD_W-1:0] r_shift;
   logic [BC_W-1:0]   r_bit_cnt;
   logic [WORD_W-1:0] r_word_out;
   logic [ADDR_W-1:0] r_addr_cnt;
   logic [ADDR_W-1:0] r_address;
   logic              r_write_pulse;
   logic [CNT_W-1:0]  r_byte_cnt;
   logic              r_frame_error;

   spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'(CPOL))) u_sync_sclk (
      .clk(clk), .reset(reset), .i_d(bus.spi_sclk), .o_q(w_sclk_s));
   spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .reset(reset), .i_d(bus.spi_mosi), .o_q(w_mosi_s));
   spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .clk(clk), .reset(reset), .i_d(bus.spi_cs_n), .o_q(w_cs_s));

   assign w_edge    = (SAMPLE_RISE ? (w_sclk_s & ~r_sclk_d) : (~w_sclk_s & r_sclk_d)) & ~w_cs_s;
   assign w_cs_rise = w_cs_s & ~r_cs_d;

   always_comb begin
      w_next_word = r_shift;
      if (MSB_FIRST != 0) w_next_word = {r_shift[WORD_W-2:0], w_mosi_s};
      else                w_next_word = {w_mosi_s, r_shift[WORD_W-1:1]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // Delay flops start at the synchroniser reset values so that
         // release from reset never looks like an sclk or cs_n edge.
         r_sclk_d      <= 1'(CPOL);
         r_cs_d        <= 1'b1;
         r_shift       <= '0;
         r_bit_cnt     <= '0;
         r_word_out    <= '0;
         r_addr_cnt    <= '0;
         r_address     <= '0;
         r_write_pulse <= 1'b0;
         r_byte_cnt    <= '0;
         r_frame_error <= 1'b0;
      end else begin
         r_sclk_d      <= w_sclk_s;
         r_cs_d        <= w_cs_s;
         r_write_pulse <= 1'b0;
         if (bus.clear) begin
            // Clear beats a completing word: no pulse, counters zeroed.
            r_bit_cnt     <= '0;
            r_addr_cnt    <= '0;
            r_address     <= '0;
            r_byte_cnt    <= '0;
            r_frame_error <= 1'b0;
         end else if (w_cs_rise) begin
            // End of frame beats a coincident sample edge; partial word dropped.
            r_bit_cnt <= '0;
            if (r_bit_cnt != '0) r_frame_error <= 1'b1;
         end else if (w_edge) begin
            r_shift <= w_next_word;
            if (r_bit_cnt == BC_W'(WORD_W-1)) begin
               r_word_out    <= w_next_word;
               r_write_pulse <= 1'b1;
               r_address     <= r_addr_cnt;
               r_addr_cnt    <= r_addr_cnt + ADDR_W'(1);
               r_byte_cnt    <= r_byte_cnt + CNT_W'(bytes_per_word(WORD_W));
               r_bit_cnt     <= '0;
            end else begin
               r_bit_cnt <= r_bit_cnt + BC_W'(1);
            end
         end
      end
   end

   assign bus.word_out     = r_word_out;
   assign bus.address      = r_address;
   assign bus.write_pulse  = r_write_pulse;
   assign bus.byte_count   = r_byte_cnt;
   assign bus.frame_active = ~w_cs_s;
   assign bus.frame_error  = r_frame_error;
endmodule

// File: tb/tb_spi_word_receiver.sv
// Bench for spi_word_receiver: six instances (modes 0..3, LSB-first, 2-bit
// address) share one SPI stream; CPOL=1 instances see the inverted clock.
`timescale 1ns/1ps
module tb_spi_word_receiver;
   localparam int NI = 6;

   logic clk = 1'b0;
   logic reset, clear, sclk_a, mosi, cs_n;

   always #5 clk = ~clk;

   spi_word_receiver_if #(.WORD_W(16), .ADDR_W(15), .CNT_W(16)) if0 ();
   spi_word_receiver_if #(.WORD_W(16), .ADDR_W(15), .CNT_W(16)) if1 ();
   spi_word_receiver_if #(.WORD_W(16), .ADDR_W(15), .CNT_W(16)) if2 ();
   spi_word_receiver_if #(.WORD_W(16), .ADDR_W(15), .CNT_W(16)) if3 ();
   spi_word_receiver_if #(.WORD_W(16), .ADDR_W(15), .CNT_W(16)) if4 ();
   spi_word_receiver_if #(.WORD_W(16), .ADDR_W(2),  .CNT_W(16)) if5 ();

   assign if0.clear = clear; assign if0.spi_sclk = sclk_a;  assign if0.spi_mosi = mosi; assign if0.spi_cs_n = cs_n;
   assign if1.clear = clear; assign if1.spi_sclk = sclk_a;  assign if1.spi_mosi = mosi; assign if1.spi_cs_n = cs_n;
   assign if2.clear = clear; assign if2.spi_sclk = ~sclk_a; assign if2.spi_mosi = mosi; assign if2.spi_cs_n = cs_n;
   assign if3.clear = clear; assign if3.spi_sclk = ~sclk_a; assign if3.spi_mosi = mosi; assign if3.spi_cs_n = cs_n;
   assign if4.clear = clear; assign if4.spi_sclk = sclk_a;  assign if4.spi_mosi = mosi; assign if4.spi_cs_n = cs_n;
   assign if5.clear = clear; assign if5.spi_sclk = sclk_a;  assign if5.spi_mosi = mosi; assign if5.spi_cs_n = cs_n;

   spi_word_receiver #(.WORD_W(16), .ADDR_W(15), .CNT_W(16), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2))
      u0 (.clk(clk), .reset(reset), .bus(if0));
   spi_word_receiver #(.WORD_W(16), .ADDR_W(15), .CNT_W(16), .CPOL(0), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2))
      u1 (.clk(clk), .reset(reset), .bus(if1));
   spi_word_receiver #(.WORD_W(16), .ADDR_W(15), .CNT_W(16), .CPOL(1), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2))
      u2 (.clk(clk), .reset(reset), .bus(if2));
   spi_word_receiver #(.WORD_W(16), .ADDR_W(15), .CNT_W(16), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(3))
      u3 (.clk(clk), .reset(reset), .bus(if3));
   spi_word_receiver #(.WORD_W(16), .ADDR_W(15), .CNT_W(16), .CPOL(0), .CPHA(0), .MSB_FIRST(0), .SYNC_STAGES(2))
      u4 (.clk(clk), .reset(reset), .bus(if4));
   spi_word_receiver #(.WORD_W(16), .ADDR_W(2),  .CNT_W(16), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2))
      u5 (.clk(clk), .reset(reset), .bus(if5));

   logic [15:0] wo[NI];
   logic [14:0] ad[NI];
   logic [15:0] bc[NI];
   logic        wp[NI], fe[NI], fa[NI];

   assign wo[0] = if0.word_out; assign ad[0] = if0.address;       assign bc[0] = if0.byte_count;
   assign wo[1] = if1.word_out; assign ad[1] = if1.address;       assign bc[1] = if1.byte_count;
   assign wo[2] = if2.word_out; assign ad[2] = if2.address;       assign bc[2] = if2.byte_count;
   assign wo[3] = if3.word_out; assign ad[3] = if3.address;       assign bc[3] = if3.byte_count;
   assign wo[4] = if4.word_out; assign ad[4] = if4.address;       assign bc[4] = if4.byte_count;
   assign wo[5] = if5.word_out; assign ad[5] = 15'(if5.address);  assign bc[5] = if5.byte_count;
   assign wp[0] = if0.write_pulse; assign fe[0] = if0.frame_error; assign fa[0] = if0.frame_active;
   assign wp[1] = if1.write_pulse; assign fe[1] = if1.frame_error; assign fa[1] = if1.frame_active;
   assign wp[2] = if2.write_pulse; assign fe[2] = if2.frame_error; assign fa[2] = if2.frame_active;
   assign wp[3] = if3.write_pulse; assign fe[3] = if3.frame_error; assign fa[3] = if3.frame_active;
   assign wp[4] = if4.write_pulse; assign fe[4] = if4.frame_error; assign fa[4] = if4.frame_active;
   assign wp[5] = if5.write_pulse; assign fe[5] = if5.frame_error; assign fa[5] = if5.frame_active;

   // Every write pulse, sampled mid-cycle, is logged per instance.
   logic [15:0] cap_w[NI][256];
   logic [14:0] cap_a[NI][256];
   int          cap_n[NI] = '{default: 0};

   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (wp[k] === 1'b1 && cap_n[k] < 256) begin
            cap_w[k][cap_n[k]] <= wo[k];
            cap_a[k][cap_n[k]] <= ad[k];
            cap_n[k]           <= cap_n[k] + 1;
         end
      end
   end

   int n_chk  = 0;
   int n_fail = 0;
   int base[NI];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic snap();
      for (int k = 0; k < NI; k++) base[k] = cap_n[k];
   endtask

   function automatic logic [15:0] rev16(input logic [15:0] v);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) r[i] = v[15-i];
      return r;
   endfunction

   // mosi is stable across both sclk edges, so the same bit is valid for
   // leading-edge (CPHA=0) and trailing-edge (CPHA=1) sampling.
   task automatic send_bit(input logic b, input bit with_clr);
      mosi = b;
      #40;
      sclk_a = 1'b1;
      if (with_clr) begin #1; clear = 1'b1; #39; end
      else #40;
      sclk_a = 1'b0;
      #40;
      if (with_clr) begin #80; clear = 1'b0; end
   endtask

   task automatic send_word(input logic [15:0] w);
      for (int i = 15; i >= 0; i--) send_bit(w[i], 1'b0);
   endtask

   task automatic cs_low();
      cs_n = 1'b0; #80;
   endtask

   task automatic cs_high();
      #80; cs_n = 1'b1; #80;
   endtask

   task automatic chk_new(input string tag, input int k, input int idx,
                          input logic [15:0] ew, input logic [14:0] ea);
      chk($sformatf("%s word u%0d #%0d", tag, k, idx), {16'h0, cap_w[k][base[k]+idx]}, {16'h0, ew});
      chk($sformatf("%s addr u%0d #%0d", tag, k, idx), {17'h0, cap_a[k][base[k]+idx]}, {17'h0, ea});
   endtask

   typedef struct {
      logic [15:0] tx;
      logic [15:0] exp_msb;
      logic [15:0] exp_lsb;
      logic [14:0] exp_addr;
      logic [14:0] exp_addr_n;
   } vec_t;
   vec_t tab[5];

   // Reference model for random frames: the stream of completed words since
   // the last reset, plus the sticky truncated-frame flag.
   logic [15:0] exp_q[$];
   logic        exp_err;
   logic        fb[64];

   task automatic check_model(input string tag);
      int n, m;
      logic [15:0] w;
      for (int k = 0; k < NI; k++) begin
         n = cap_n[k] - base[k];
         chk($sformatf("%s count u%0d", tag, k), n, exp_q.size());
         m = (n < exp_q.size()) ? n : exp_q.size();
         for (int j = 0; j < m; j++) begin
            w = exp_q[j];
            chk_new(tag, k, j, (k == 4) ? rev16(w) : w, (k == 5) ? 15'(j % 4) : 15'(j % 32768));
         end
         chk($sformatf("%s byte_count u%0d", tag, k), bc[k], 32'((2 * exp_q.size()) % 65536));
         chk($sformatf("%s frame_error u%0d", tag, k), fe[k], exp_err);
      end
   endtask

   initial begin
      int nb;
      logic [15:0] w;

      tab[0] = '{16'hA55A, 16'hA55A, 16'h5AA5, 15'd0, 15'd0};
      tab[1] = '{16'h1234, 16'h1234, 16'h2C48, 15'd1, 15'd1};
      tab[2] = '{16'h00F1, 16'h00F1, 16'h8F00, 15'd2, 15'd2};
      tab[3] = '{16'hBEEF, 16'hBEEF, 16'hF77D, 15'd3, 15'd3};
      tab[4] = '{16'h0003, 16'h0003, 16'hC000, 15'd4, 15'd0};

      reset = 1'b1; clear = 1'b0; cs_n = 1'b1; sclk_a = 1'b0; mosi = 1'b0;
      #22;
      chk("rst word_out", wo[0], 0);
      chk("rst address", ad[0], 0);
      chk("rst write_pulse", wp[0], 0);
      chk("rst byte_count", bc[0], 0);
      chk("rst frame_active", fa[0], 0);
      chk("rst frame_error", fe[0], 0);
      reset = 1'b0;
      #20;

      // Directed table: five words in one frame, every instance.
      snap();
      cs_low();
      for (int i = 0; i < 5; i++) send_word(tab[i].tx);
      for (int k = 0; k < NI; k++) chk($sformatf("frame_active u%0d", k), fa[k], 1);
      cs_high();
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("tab count u%0d", k), cap_n[k] - base[k], 5);
         for (int i = 0; i < 5 && i < cap_n[k] - base[k]; i++)
            chk_new("tab", k, i, (k == 4) ? tab[i].exp_lsb : tab[i].exp_msb,
                    (k == 5) ? tab[i].exp_addr_n : tab[i].exp_addr);
         chk($sformatf("tab byte_count u%0d", k), bc[k], 10);
         chk($sformatf("tab frame_error u%0d", k), fe[k], 0);
         chk($sformatf("idle frame_active u%0d", k), fa[k], 0);
      end

      // Truncated frame of 7 bits, then a full 0xBEEF.
      snap();
      cs_low();
      for (int i = 6; i >= 0; i--) send_bit(1'(7'h55 >> i), 1'b0);
      cs_high();
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("trunc frame_error u%0d", k), fe[k], 1);
         chk($sformatf("trunc no pulse u%0d", k), cap_n[k] - base[k], 0);
      end
      cs_low();
      send_word(16'hBEEF);
      cs_high();
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("beef count u%0d", k), cap_n[k] - base[k], 1);
         if (cap_n[k] > base[k])
            chk_new("beef", k, 0, (k == 4) ? 16'hF77D : 16'hBEEF, (k == 5) ? 15'd1 : 15'd5);
         chk($sformatf("sticky frame_error u%0d", k), fe[k], 1);
         chk($sformatf("beef byte_count u%0d", k), bc[k], 12);
      end

      // Clear held across the completion of a word.
      snap();
      cs_low();
      w = 16'h0F0F;
      for (int i = 15; i >= 1; i--) send_bit(w[i], 1'b0);
      send_bit(w[0], 1'b1);
      cs_high();
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("clr no pulse u%0d", k), cap_n[k] - base[k], 0);
         chk($sformatf("clr address u%0d", k), ad[k], 0);
         chk($sformatf("clr byte_count u%0d", k), bc[k], 0);
         chk($sformatf("clr frame_error u%0d", k), fe[k], 0);
      end
      cs_low();
      send_word(16'h1234);
      send_word(16'hA55A);
      cs_high();
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("post-clr count u%0d", k), cap_n[k] - base[k], 2);
         if (cap_n[k] - base[k] >= 2) begin
            chk_new("post-clr", k, 0, (k == 4) ? 16'h2C48 : 16'h1234, 15'd0);
            chk_new("post-clr", k, 1, (k == 4) ? 16'h5AA5 : 16'hA55A, 15'd1);
         end
         chk($sformatf("post-clr byte_count u%0d", k), bc[k], 4);
      end

      // Asynchronous reset in the middle of a word.
      cs_low();
      for (int i = 6; i >= 0; i--) send_bit(1'b1, 1'b0);
      #4 reset = 1'b1;
      #1;
      chk("midrst word_out", wo[0], 0);
      chk("midrst address", ad[0], 0);
      chk("midrst write_pulse", wp[0], 0);
      chk("midrst byte_count", bc[0], 0);
      chk("midrst frame_active", fa[0], 0);
      chk("midrst frame_error", fe[0], 0);
      #5;
      cs_n = 1'b1; #40;
      reset = 1'b0; #40;
      snap();
      cs_low();
      send_word(16'hA55A);
      cs_high();
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("after-rst count u%0d", k), cap_n[k] - base[k], 1);
         if (cap_n[k] > base[k]) chk_new("after-rst", k, 0, (k == 4) ? 16'h5AA5 : 16'hA55A, 15'd0);
         chk($sformatf("after-rst byte_count u%0d", k), bc[k], 2);
         chk($sformatf("after-rst frame_error u%0d", k), fe[k], 0);
      end

      // Random frames against the reference model.
      reset = 1'b1; #20; reset = 1'b0; #20;
      snap();
      exp_q.delete();
      exp_err = 1'b0;
      for (int f = 0; f < 12; f++) begin
         nb = (f % 3 == 0) ? 16 * $urandom_range(1, 2) : $urandom_range(1, 40);
         for (int i = 0; i < nb; i++) fb[i] = 1'($urandom_range(0, 1));
         cs_low();
         for (int i = 0; i < nb; i++) send_bit(fb[i], 1'b0);
         cs_high();
         for (int j = 0; j < nb / 16; j++) begin
            for (int i = 0; i < 16; i++) w[15-i] = fb[16*j + i];
            exp_q.push_back(w);
         end
         if (nb % 16 != 0) exp_err = 1'b1;
      end
      check_model("rand");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
